// File: rtl/seq_multiplier.sv
// Sequential 8x8 -> 16-bit unsigned shift-and-add multiplier around an 8-bit ripple adder.
// Optional feature macro: MULT_ZERO_SKIP_EN (zero operand completes in one cycle, busy stays low).

module adder_zero (
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  output logic [8:0] out
);
  logic [8:0] carry;

  assign carry[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_fa
      assign out[gi]       = in0[gi] ^ in1[gi] ^ carry[gi];
      assign carry[gi + 1] = (in0[gi] & in1[gi]) | (carry[gi] & (in0[gi] ^ in1[gi]));
    end
  endgenerate

  assign out[8] = carry[8];
endmodule

module seq_multiplier (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] product,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q;
  logic [7:0]  m_q;
  logic [7:0]  a_q;
  logic [7:0]  q_q;
  logic [3:0]  cnt_q;
  logic [15:0] product_q;
  logic        busy_q;
  logic        done_q;
  logic        skip_q;

  logic [7:0]  addend;
  logic [8:0]  sum;
  logic [7:0]  a_d;
  logic [7:0]  q_d;
  logic        zero_op;

  assign addend = q_q[0] ? m_q : 8'h00;

  adder_zero u_adder (
    .in0 (a_q),
    .in1 (addend),
    .out (sum)
  );

  // The adder carry lands in A[7] after the shift, so no product bit is lost.
  assign a_d = sum[8:1];
  assign q_d = {sum[0], q_q[7:1]};

`ifdef MULT_ZERO_SKIP_EN
  assign zero_op = (a == 8'h00) || (b == 8'h00);
`else
  assign zero_op = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      m_q       <= 8'h00;
      a_q       <= 8'h00;
      q_q       <= 8'h00;
      cnt_q     <= 4'd0;
      product_q <= 16'h0000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      skip_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (start) begin
            m_q     <= a;
            q_q     <= b;
            a_q     <= 8'h00;
            cnt_q   <= 4'd0;
            busy_q  <= ~zero_op;
            skip_q  <= zero_op;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (skip_q) begin
            // Zero operand: spend one silent cycle so done lands after edge 1.
            product_q <= 16'h0000;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            skip_q    <= 1'b0;
            state_q   <= DONE;
          end else begin
            a_q   <= a_d;
            q_q   <= q_d;
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              product_q <= {a_d, q_d};
              done_q    <= 1'b1;
              busy_q    <= 1'b0;
              state_q   <= DONE;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign product = product_q;
  assign busy    = busy_q;
  assign done    = done_q;
endmodule
